// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 1-cycle SRAM data store.
// Optional hit/miss counters are enabled with CACHE_STATS_EN.
package cache_pkg;
  localparam int NumSets       = 64;
  localparam int Associativity = 1;
  localparam int TagWidth      = 4;
  localparam int SetWidth      = $clog2(NumSets);
  localparam int AddrWidth     = TagWidth + SetWidth;
  localparam int DataWidth     = 4;

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  typedef logic [DataWidth-1:0] block_data_t;
endpackage

module cache_ctrl
  import cache_pkg::*;
#(
  parameter int StatsWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_req_write_o,
  output logic [AddrWidth-1:0] mem_req_addr_o,
  output logic [DataWidth-1:0] mem_req_wdata_o,
  input  logic                 mem_rsp_valid_i,
`ifdef CACHE_STATS_EN
  input  logic [DataWidth-1:0] mem_rsp_rdata_i,
  output logic [StatsWidth-1:0] hit_count_o,
  output logic [StatsWidth-1:0] miss_count_o
`else
  input  logic [DataWidth-1:0] mem_rsp_rdata_i
`endif
);

  if (Associativity != 1) begin : g_assoc_chk
    $error("cache_ctrl supports only Associativity == 1");
  end
  if (StatsWidth < 1) begin : g_stats_chk
    $error("cache_ctrl StatsWidth must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, WR_MEM, RESP} state_e;

  state_e                state_q, state_d;
  logic                  write_q;
  logic [TagWidth-1:0]   tag_q;
  logic [SetWidth-1:0]   set_q;
  block_data_t           wdata_q, rdata_q;
  block_info_t [NumSets-1:0] info_q;

  block_data_t           sram [NumSets];
  block_data_t           sram_rdata, sram_wdata;
  logic [SetWidth-1:0]   sram_addr;
  logic                  sram_we, sram_re;
  logic                  hit;

  assign hit = info_q[set_q].valid && (info_q[set_q].tag == tag_q);

  // Data store: no reset, read data valid the cycle after the read strobe.
  always_ff @(posedge clk_i) begin
    if (sram_we) sram[sram_addr] <= sram_wdata;
    else if (sram_re) sram_rdata <= sram[sram_addr];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    req_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_write_o = 1'b0;
    sram_we         = 1'b0;
    sram_re         = 1'b0;
    sram_addr       = set_q;
    sram_wdata      = mem_rsp_rdata_i;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        sram_addr   = req_addr_i[SetWidth-1:0];
        if (req_valid_i) begin
          sram_re = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (write_q) begin
          state_d = WR_MEM;
          if (hit) begin
            sram_we    = 1'b1;
            sram_wdata = wdata_q;
          end
        end else begin
          state_d = hit ? RESP : MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_rsp_valid_i) begin
          sram_we = 1'b1;
          state_d = RESP;
        end
      end
      WR_MEM: begin
        mem_req_valid_o = 1'b1;
        mem_req_write_o = 1'b1;
        if (mem_req_ready_i) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_addr_o  = mem_req_valid_o ? {tag_q, set_q} : '0;
  assign mem_req_wdata_o = mem_req_write_o ? wdata_q : '0;
  assign rsp_rdata_o     = rsp_valid_o ? rdata_q : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q <= 1'b0;
      tag_q   <= '0;
      set_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      info_q  <= '0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        write_q <= req_write_i;
        tag_q   <= req_addr_i[AddrWidth-1:SetWidth];
        set_q   <= req_addr_i[SetWidth-1:0];
        wdata_q <= req_wdata_i;
      end
      if (state_q == LOOKUP) begin
        if (write_q)  rdata_q <= '0;
        else if (hit) rdata_q <= sram_rdata;
      end
      // Refill replaces whatever tag previously owned the set.
      if (state_q == MISS_WAIT && mem_rsp_valid_i) begin
        rdata_q       <= mem_rsp_rdata_i;
        info_q[set_q] <= '{valid: 1'b1, tag: tag_q};
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [StatsWidth-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP && !write_q) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed scoreboard bench for cache_ctrl: hits, misses, eviction, write-through,
// back-pressure, reset mid-refill, and (with CACHE_STATS_EN) the hit/miss counters.
module tb_cache_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i, req_ready_o, req_write_i;
  logic [9:0] req_addr_i;
  logic [3:0] req_wdata_i;
  logic       rsp_valid_o, rsp_ready_i;
  logic [3:0] rsp_rdata_o;
  logic       mem_req_valid_o, mem_req_ready_i, mem_req_write_o;
  logic [9:0] mem_req_addr_o;
  logic [3:0] mem_req_wdata_o;
  logic       mem_rsp_valid_i;
  logic [3:0] mem_rsp_rdata_i;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_o, miss_count_o;
`endif

  cache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_write_o(mem_req_write_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_rsp_valid_i(mem_rsp_valid_i),
`ifdef CACHE_STATS_EN
    .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`else
    .mem_rsp_rdata_i(mem_rsp_rdata_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       w;
    logic [9:0] a;
    logic [3:0] d;
  } mreq_t;

  mreq_t      mreq_q[$];
  logic [3:0] rsp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Compare the memory request on the bus against the next scoreboard entry.
  task automatic chk_mreq(input string tag);
    mreq_t m;
    if (mreq_q.size() == 0) begin
      chk({tag, "_unexpected"}, mem_req_valid_o, 0);
    end else begin
      m = mreq_q.pop_front();
      chk({tag, "_write"}, mem_req_write_o, m.w);
      chk({tag, "_addr"}, mem_req_addr_o, m.a);
      chk({tag, "_wdata"}, mem_req_wdata_o, m.d);
    end
  endtask

  task automatic chk_rsp(input string tag);
    logic [3:0] e;
    if (rsp_q.size() == 0) begin
      chk({tag, "_unexpected"}, rsp_valid_o, 0);
    end else begin
      e = rsp_q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata_o, e);
    end
  endtask

  // One request with ready inputs high; hit says whether the read is served locally.
  task automatic transact(input string tag, input logic w, input logic [9:0] a,
                          input logic [3:0] wd, input logic hit, input logic [3:0] refill,
                          input logic [3:0] exp_rd);
    int cyc;
    logic done;
    int exp_lat;
    exp_lat = w ? 3 : (hit ? 2 : 4);
    rsp_q.push_back(exp_rd);
    if (w || !hit) mreq_q.push_back('{w, a, w ? wd : 4'h0});
    chk({tag, "_req_ready"}, req_ready_o, 1);
    req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = wd;
    step();
    req_valid_i = 1'b0;
    cyc = 1;
    done = 1'b0;
    while (!done && cyc < 20) begin
      if (mem_req_valid_o) begin
        chk({tag, "_mem_lat"}, cyc, 2);
        chk_mreq({tag, "_mem"});
        if (!mem_req_write_o) begin
          step(); cyc++;
          mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = refill;
          step(); cyc++;
          mem_rsp_valid_i = 1'b0;
          continue;
        end
      end
      if (rsp_valid_o) begin
        chk({tag, "_rsp_lat"}, cyc, exp_lat);
        chk_rsp(tag);
        done = 1'b1;
      end else begin
        chk({tag, "_busy_ready"}, req_ready_o, 0);
      end
      step(); cyc++;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 0; req_write_i = 0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1; mem_req_ready_i = 1; mem_rsp_valid_i = 0; mem_rsp_rdata_i = '0;
    step(); step();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_mem_valid", mem_req_valid_o, 0);
    chk("rst_outputs", {mem_req_write_o, mem_req_addr_o, mem_req_wdata_o, rsp_rdata_o}, 0);
    rst_i = 1'b0;
    step();

    // 1: cold miss then hit
    transact("t1_miss", 0, 10'h2A5, 4'h0, 0, 4'h7, 4'h7);
    transact("t1_hit",  0, 10'h2A5, 4'h0, 1, 4'h0, 4'h7);
    // 2: same set, other tag evicts
    transact("t2_alias", 0, 10'h0A5, 4'h0, 0, 4'h3, 4'h3);
    transact("t2_evict", 0, 10'h2A5, 4'h0, 0, 4'h7, 4'h7);
    // 3: write hit updates line, write miss does not allocate
    transact("t3_wr_hit",  1, 10'h2A5, 4'hC, 1, 4'h0, 4'h0);
    transact("t3_rd_hit",  0, 10'h2A5, 4'h0, 1, 4'h0, 4'hC);
    transact("t3_wr_miss", 1, 10'h111, 4'h5, 0, 4'h0, 4'h0);
    transact("t3_rd_miss", 0, 10'h111, 4'h0, 0, 4'h5, 4'h5);

    // 4: back-pressure on memory and response sides
    mreq_q.push_back('{1'b0, 10'h0A5, 4'h0});
    rsp_q.push_back(4'h9);
    mem_req_ready_i = 1'b0;
    req_valid_i = 1; req_write_i = 0; req_addr_i = 10'h0A5;
    step();
    req_valid_i = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_mem_valid", mem_req_valid_o, 1);
      chk("t4_mem_payload", {mem_req_write_o, mem_req_addr_o}, {1'b0, 10'h0A5});
      chk("t4_req_ready", req_ready_o, 0);
      step();
    end
    mem_req_ready_i = 1'b1;
    chk_mreq("t4_mem");
    step();
    rsp_ready_i = 1'b0;
    mem_rsp_valid_i = 1; mem_rsp_rdata_i = 4'h9;
    step();
    mem_rsp_valid_i = 0; mem_rsp_rdata_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_rsp_valid", rsp_valid_o, 1);
      chk("t4_rsp_rdata", rsp_rdata_o, 4'h9);
      chk("t4_rsp_ready", req_ready_o, 0);
      step();
    end
    rsp_ready_i = 1'b1;
    chk_rsp("t4_rsp");
    step();
    chk("t4_idle", req_ready_o, 1);

    // 5: reset while waiting for refill; late response must be dropped
    req_valid_i = 1; req_write_i = 0; req_addr_i = 10'h3C0;
    step();
    req_valid_i = 0;
    step();
    chk("t5_mem_req", mem_req_valid_o, 1);
    step();
    chk("t5_wait_ready", req_ready_o, 0);
    rst_i = 1'b1;
    #2;
    chk("t5_rst_ready", req_ready_o, 1);
    chk("t5_rst_mem", mem_req_valid_o, 0);
    rst_i = 1'b0;
    step();
    mem_rsp_valid_i = 1; mem_rsp_rdata_i = 4'hE;
    step();
    mem_rsp_valid_i = 0;
    chk("t5_late_rsp", rsp_valid_o, 0);
    chk("t5_idle", req_ready_o, 1);
    transact("t5_rd_miss", 0, 10'h3C0, 4'h0, 0, 4'h1, 4'h1);
    transact("t5_inval",   0, 10'h2A5, 4'h0, 0, 4'hC, 4'hC);

`ifdef CACHE_STATS_EN
    // 6: counters over a fresh reset
    rst_i = 1'b1; step(); rst_i = 1'b0; step();
    chk("t6_rst_hits", hit_count_o, 0);
    transact("t6_m0", 0, 10'h2A5, 4'h0, 0, 4'h7, 4'h7);
    transact("t6_h0", 0, 10'h2A5, 4'h0, 1, 4'h0, 4'h7);
    transact("t6_h1", 0, 10'h2A5, 4'h0, 1, 4'h0, 4'h7);
    transact("t6_w",  1, 10'h2A5, 4'h6, 1, 4'h0, 4'h0);
    transact("t6_h2", 0, 10'h2A5, 4'h0, 1, 4'h0, 4'h6);
    transact("t6_m1", 0, 10'h0A5, 4'h0, 0, 4'h3, 4'h3);
    chk("t6_hits", hit_count_o, 3);
    chk("t6_misses", miss_count_o, 2);
    force dut.hit_cnt_q = 16'hFFFF;
    step();
    release dut.hit_cnt_q;
    transact("t6_sat", 0, 10'h0A5, 4'h0, 1, 4'h0, 4'h3);
    chk("t6_saturate", hit_count_o, 16'hFFFF);
`endif

    chk("sb_empty", rsp_q.size() + mreq_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
